// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and sizing helpers for the 8088 HOLD/HLDA bus arbiter.
//   state_t     : arbiter FSM states
//   DEF_*       : default parameter values used by the top level
//   idx_width() : width of a requester index for a given requester count
//   cnt_width() : width of a counter that must hold values 0..max_val
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HLDA = 3'd1,
    S_GRANT     = 3'd2,
    S_HANDOFF   = 3'd3,
    S_RELEASE   = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_MAX_TENURE = 16;
  localparam int DEF_MAX_CHAIN  = 2;
  localparam int DEF_MIN_GAP    = 4;

  // Index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_hold_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_req starting at i_ptr and
// wrapping modulo NREQ; the first set bit found wins.
//   i_req    : request vector
//   i_ptr    : search start index
//   o_valid  : at least one request present
//   o_idx    : winning index (0 when no request)
//   o_onehot : one-hot form of the winner (all zero when no request)
// ---------------------------------------------------------------------------
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot
);

  logic [IW:0] w_cand;

  // Scan from the farthest position back toward the pointer so the last
  // hit written is the closest one after the pointer.
  always_comb begin
    o_idx  = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, i_ptr} + (IW + 1)'(k);
      w_cand = (w_cand >= (IW + 1)'(NREQ)) ? (w_cand - (IW + 1)'(NREQ)) : w_cand;
      o_idx  = i_req[w_cand[IW-1:0]] ? w_cand[IW-1:0] : o_idx;
    end
    o_valid  = |i_req;
    o_onehot = o_valid ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/bus_hold_arbiter.sv
// ---------------------------------------------------------------------------
// bus_hold_arbiter
// Shares the 8088 local bus between the CPU and NREQ bus masters. Raises
// HOLD toward the CPU, waits for HLDA, then grants the bus round-robin with
// bounded tenure and a bounded number of back-to-back grants per episode.
// After HOLD is released the CPU keeps the bus for at least MIN_GAP cycles.
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset
//   REQ   : per-requester level request
//   HLDA  : hold acknowledge from the CPU
//   HOLD  : hold request to the CPU
//   GNT   : one-hot grant (or zero)
//   BUSEN : high whenever any GNT bit is high
//   OWNER : index of current / last grantee
//   ERR   : one-cycle pulse when HLDA drops while the bus is lent out
// ---------------------------------------------------------------------------
module bus_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NREQ       = DEF_NREQ,
  parameter  int MAX_TENURE = DEF_MAX_TENURE,
  parameter  int MAX_CHAIN  = DEF_MAX_CHAIN,
  parameter  int MIN_GAP    = DEF_MIN_GAP,
  localparam int IW         = idx_width(NREQ)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic            HLDA,
  output logic            HOLD,
  output logic [NREQ-1:0] GNT,
  output logic            BUSEN,
  output logic [IW-1:0]   OWNER,
  output logic            ERR
);

  localparam int TW = cnt_width(MAX_TENURE);
  localparam int CW = cnt_width(MAX_CHAIN);
  localparam int GW = cnt_width(MIN_GAP);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [NREQ-1:0] r_gnt;
  logic            r_hold;
  logic            r_busen;
  logic            r_err;
  logic [TW-1:0]   r_ten;
  logic [CW-1:0]   r_chain;
  logic [GW-1:0]   r_gap;

  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic [NREQ-1:0] w_pick_onehot;
  logic [IW-1:0]   w_next_ptr;
  logic            w_grant_end;
  logic            w_chain_more;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (REQ),
    .i_ptr    (r_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  // Pointer position just past the current owner, wrapping at NREQ.
  assign w_next_ptr   = (r_owner == IW'(NREQ - 1)) ? '0 : (r_owner + IW'(1));
  // Owner finished or used up its tenure; both collapse into one grant end.
  assign w_grant_end  = !REQ[r_owner] || (r_ten == TW'(MAX_TENURE));
  // An expired owner still requesting counts as pending here.
  assign w_chain_more = (|REQ) && (r_chain < CW'(MAX_CHAIN));

  // Arbiter FSM and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_hold  <= 1'b0;
      r_busen <= 1'b0;
      r_err   <= 1'b0;
      r_ten   <= '0;
      r_chain <= '0;
      r_gap   <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|REQ) begin
            r_state <= S_WAIT_HLDA;
            r_hold  <= 1'b1;
          end
        end
        S_WAIT_HLDA: begin
          if (!(|REQ)) begin
            r_state <= S_RELEASE;
            r_hold  <= 1'b0;
          end else if (HLDA) begin
            r_state <= S_GRANT;
            r_gnt   <= w_pick_onehot;
            r_busen <= 1'b1;
            r_owner <= w_pick_idx;
            r_chain <= CW'(1);
            r_ten   <= TW'(1);
          end
        end
        S_GRANT: begin
          if (!HLDA) begin
            // CPU took the bus back while a master owned it.
            r_err   <= 1'b1;
            r_gnt   <= '0;
            r_busen <= 1'b0;
            r_hold  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= S_RELEASE;
          end else if (w_grant_end) begin
            r_gnt   <= '0;
            r_busen <= 1'b0;
            r_ptr   <= w_next_ptr;
            if (w_chain_more) begin
              r_state <= S_HANDOFF;
            end else begin
              r_state <= S_RELEASE;
              r_hold  <= 1'b0;
            end
          end else begin
            r_ten <= r_ten + TW'(1);
          end
        end
        S_HANDOFF: begin
          if (!HLDA) begin
            r_err   <= 1'b1;
            r_hold  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= S_RELEASE;
          end else if (w_pick_valid) begin
            r_state <= S_GRANT;
            r_gnt   <= w_pick_onehot;
            r_busen <= 1'b1;
            r_owner <= w_pick_idx;
            r_chain <= r_chain + CW'(1);
            r_ten   <= TW'(1);
          end else begin
            r_state <= S_RELEASE;
            r_hold  <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!HLDA) begin
            if (MIN_GAP == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
              r_gap   <= GW'(1);
            end
          end
        end
        S_GAP: begin
          // REQ is deliberately not looked at until the gap has elapsed.
          if (r_gap == GW'(MIN_GAP)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busen <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign HOLD  = r_hold;
  assign GNT   = r_gnt;
  assign BUSEN = r_busen;
  assign OWNER = r_owner;
  assign ERR   = r_err;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_hold_arbiter
// Drives directed scenarios followed by randomized requester / CPU traffic.
// A behavioural model predicts the outputs after every edge and pushes them
// into a scoreboard queue; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_bus_hold_arbiter;

  localparam int NREQ       = 4;
  localparam int MAX_TENURE = 16;
  localparam int MAX_CHAIN  = 2;
  localparam int MIN_GAP    = 4;
  localparam int IW         = $clog2(NREQ);

  // Model phases (names follow the behaviour, not any RTL encoding).
  localparam int P_IDLE  = 0;
  localparam int P_ASK   = 1;
  localparam int P_LENT  = 2;
  localparam int P_TURN  = 3;
  localparam int P_LETGO = 4;
  localparam int P_REST  = 5;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [NREQ-1:0] REQ;
  logic            HLDA;
  logic            HOLD;
  logic [NREQ-1:0] GNT;
  logic            BUSEN;
  logic [IW-1:0]   OWNER;
  logic            ERR;

  always #5 CLK = ~CLK;

  bus_hold_arbiter #(
    .NREQ(NREQ), .MAX_TENURE(MAX_TENURE), .MAX_CHAIN(MAX_CHAIN), .MIN_GAP(MIN_GAP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .HLDA(HLDA),
    .HOLD(HOLD), .GNT(GNT), .BUSEN(BUSEN), .OWNER(OWNER), .ERR(ERR)
  );

  typedef struct packed {
    logic            hold;
    logic [NREQ-1:0] gnt;
    logic            busen;
    logic [IW-1:0]   owner;
    logic            err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state.
  int m_ph    = P_IDLE;
  int m_ptr   = 0;
  int m_own   = 0;
  int m_gidx  = -1;
  int m_held  = 0;
  int m_chain = 0;
  int m_rest  = 0;
  bit m_hold  = 1'b0;
  bit m_err   = 1'b0;

  // Requester and CPU behaviour.
  logic [NREQ-1:0] req_on = '0;
  int              need[NREQ];
  logic            cpu_hlda = 1'b0;
  int              cpu_cnt  = 0;

  function automatic int rr(input logic [NREQ-1:0] rq, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (rq[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_gidx = w;
    m_own  = w;
    m_held = 1;
    m_ph   = P_LENT;
  endtask

  task automatic violate();
    m_err  = 1'b1;
    m_gidx = -1;
    m_hold = 1'b0;
    m_ptr  = (m_own + 1) % NREQ;
    m_ph   = P_LETGO;
  endtask

  // Advance the model across one clock edge with the inputs sampled there.
  task automatic model_step(input logic rs, input logic [NREQ-1:0] rq, input logic ha);
    int w;
    m_err = 1'b0;
    if (rs) begin
      m_ph = P_IDLE; m_ptr = 0; m_own = 0; m_gidx = -1;
      m_held = 0; m_chain = 0; m_rest = 0; m_hold = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: if (rq != '0) begin m_ph = P_ASK; m_hold = 1'b1; end
        P_ASK: begin
          w = rr(rq, m_ptr);
          if (w < 0) begin m_ph = P_LETGO; m_hold = 1'b0; end
          else if (ha) begin give(w); m_chain = 1; end
        end
        P_LENT: begin
          if (!ha) violate();
          else if (!rq[m_own] || m_held == MAX_TENURE) begin
            m_gidx = -1;
            m_ptr  = (m_own + 1) % NREQ;
            if (rq != '0 && m_chain < MAX_CHAIN) m_ph = P_TURN;
            else begin m_ph = P_LETGO; m_hold = 1'b0; end
          end else m_held = m_held + 1;
        end
        P_TURN: begin
          if (!ha) violate();
          else begin
            w = rr(rq, m_ptr);
            if (w < 0) begin m_ph = P_LETGO; m_hold = 1'b0; end
            else begin give(w); m_chain = m_chain + 1; end
          end
        end
        P_LETGO: if (!ha) begin
          if (MIN_GAP == 0) m_ph = P_IDLE;
          else begin m_ph = P_REST; m_rest = MIN_GAP; end
        end
        P_REST: begin
          m_rest = m_rest - 1;
          if (m_rest == 0) m_ph = P_IDLE;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.hold  = m_hold;
    e.gnt   = (m_gidx < 0) ? '0 : (NREQ'(1) << m_gidx);
    e.busen = (m_gidx >= 0);
    e.owner = IW'(m_own);
    e.err   = m_err;
    return e;
  endfunction

  // Apply inputs for one cycle, predict the post-edge outputs, then wait.
  task automatic step(input logic rs, input logic [NREQ-1:0] rq, input logic ha);
    RESET = rs;
    REQ   = rq;
    HLDA  = ha;
    model_step(rs, rq, ha);
    sb_q.push_back(model_out());
    @(negedge CLK);
    #1;
  endtask

  // Run n cycles of requester + CPU behaviour.
  //   rnd       : random arrivals, withdrawals, violations and resets
  //   dly       : CPU HLDA response delay (0 = random per cycle)
  //   viol_held : drop HLDA once during this grant cycle number (0 = never)
  //   stop_held : return when a grant reaches this cycle number (0 = never)
  task automatic run(input int n, input bit rnd, input int dly,
                     input int viol_held, input int stop_held);
    logic ha;
    logic rs;
    int   d;
    for (int c = 0; c < n; c++) begin
      if (stop_held > 0 && m_ph == P_LENT && m_held == stop_held) return;
      for (int i = 0; i < NREQ; i++) begin
        if (req_on[i] && m_gidx == i) begin
          need[i] = need[i] - 1;
          if (need[i] <= 0) req_on[i] = 1'b0;
        end else if (rnd && !req_on[i] && $urandom_range(0, 7) == 0) begin
          req_on[i] = 1'b1;
          need[i]   = $urandom_range(1, 24);
        end else if (rnd && req_on[i] && $urandom_range(0, 63) == 0) begin
          req_on[i] = 1'b0;
        end
      end
      d = (dly > 0) ? dly : $urandom_range(1, 4);
      if (m_hold != cpu_hlda) begin
        cpu_cnt = cpu_cnt + 1;
        if (cpu_cnt >= d) begin cpu_hlda = m_hold; cpu_cnt = 0; end
      end else cpu_cnt = 0;
      ha = cpu_hlda;
      if ((viol_held > 0 && m_ph == P_LENT && m_held == viol_held) ||
          (rnd && (m_ph == P_LENT || m_ph == P_TURN) && $urandom_range(0, 99) == 0)) begin
        ha = 1'b0; cpu_hlda = 1'b0; cpu_cnt = 0; viol_held = 0;
      end
      rs = rnd && ($urandom_range(0, 499) == 0);
      step(rs, req_on, ha);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("HOLD",  32'(HOLD),  32'(e.hold));
        chk("GNT",   32'(GNT),   32'(e.gnt));
        chk("BUSEN", 32'(BUSEN), 32'(e.busen));
        chk("OWNER", 32'(OWNER), 32'(e.owner));
        chk("ERR",   32'(ERR),   32'(e.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) need[i] = 0;
    RESET = 1'b1;
    REQ   = '0;
    HLDA  = 1'b0;
    @(negedge CLK);
    #1;
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);

    // Single request, HLDA delayed, done after 5 grant cycles.
    run(10, 1'b0, 3, 0, 0);
    req_on[0] = 1'b1; need[0] = 5;
    run(40, 1'b0, 3, 0, 0);

    // All four requesting continuously: tenure expiry and chaining.
    req_on = '1;
    for (int i = 0; i < NREQ; i++) need[i] = 1000;
    run(160, 1'b0, 2, 0, 0);
    req_on = '0;
    run(30, 1'b0, 2, 0, 0);

    // Lone requester exceeding tenure.
    req_on[2] = 1'b1; need[2] = 1000;
    run(40, 1'b0, 2, 0, 0);
    req_on[2] = 1'b0;
    run(30, 1'b0, 2, 0, 0);

    // HLDA lost during the third grant cycle; pointer must move past owner.
    req_on[1] = 1'b1; need[1] = 50;
    req_on[2] = 1'b1; need[2] = 50;
    run(100, 1'b0, 2, 3, 0);
    req_on = '0;
    run(30, 1'b0, 2, 0, 0);

    // Reset while index 1 owns the bus; next grant must go to index 0.
    req_on[1] = 1'b1; need[1] = 1000;
    run(50, 1'b0, 2, 0, 2);
    step(1'b1, req_on, cpu_hlda);
    req_on[0] = 1'b1; need[0] = 6; need[1] = 6;
    run(60, 1'b0, 2, 0, 0);
    req_on = '0;
    run(40, 1'b0, 2, 0, 0);

    // Request withdrawn before HLDA arrives.
    req_on[3] = 1'b1; need[3] = 1000;
    run(2, 1'b0, 5, 0, 0);
    req_on[3] = 1'b0;
    run(20, 1'b0, 5, 0, 0);

    // Randomized traffic.
    run(4000, 1'b1, 0, 0, 0);
    req_on = '0;
    run(40, 1'b0, 2, 0, 0);

    repeat (2) @(negedge CLK);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
